// File: rtl/decoder4to10_seq_pkg.sv
// Shared definitions for the BCD decoder slice: code/data widths, the
// occupancy state encodings of the skid buffer and the decode function.
package decoder4to10_seq_pkg;

    localparam int CODE_W = 4;
    localparam int DATA_W = 10;
    localparam logic [CODE_W-1:0] MAX_CODE = 4'd9;

    // Occupancy of the two-entry skid buffer.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    // One stored beat: error flag on top of the one-hot word.
    typedef struct packed {
        logic              err;
        logic [DATA_W-1:0] data;
    } beat_t;

    // Codes above MAX_CODE are flagged and decode to an all-zero word.
    function automatic beat_t decodeBcd(input logic [CODE_W-1:0] code);
        beat_t beat;
        beat.err  = (code > MAX_CODE);
        beat.data = beat.err ? '0 : (DATA_W'(1) << code);
        return beat;
    endfunction

endpackage

// File: rtl/decoder4to10_seq_if.sv
// Stream bundle for the decoder: code input handshake, one-hot output
// handshake and the invalid-code counter. The producer/consumer side uses
// the master modport, the decoder uses the slave modport.
interface decoder4to10_seq_if #(
    parameter int ERR_CNT_W = 8
);
    import decoder4to10_seq_pkg::*;

    logic                 i_valid;
    logic                 o_ready;
    logic [CODE_W-1:0]    i_code;
    logic                 o_valid;
    logic                 i_ready;
    logic [DATA_W-1:0]    o_data;
    logic                 o_err;
    logic [ERR_CNT_W-1:0] o_err_cnt;

    modport master (
        output i_valid, i_code, i_ready,
        input  o_ready, o_valid, o_data, o_err, o_err_cnt
    );

    modport slave (
        input  i_valid, i_code, i_ready,
        output o_ready, o_valid, o_data, o_err, o_err_cnt
    );

endinterface

// File: rtl/dec_skid_buf.sv
// Generic two-entry valid/ready skid buffer. The main register drives the
// output, the skid register catches a beat accepted while the output stalls.
// The input ready is registered so it never depends on the output ready.
module dec_skid_buf
    import decoder4to10_seq_pkg::*;
#(
    parameter int WIDTH = DATA_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inValid_i,
    output logic             inReady_o,
    input  logic [WIDTH-1:0] inData_i,
    output logic             outValid_o,
    input  logic             outReady_i,
    output logic [WIDTH-1:0] outData_o
);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] mainData_q, mainData_d;
    logic [WIDTH-1:0] skidData_q, skidData_d;
    logic             ready_q, ready_d;
    logic             accept;
    logic             transfer;

    assign accept     = inValid_i & ready_q;
    assign transfer   = (state_q != ST_EMPTY) & outReady_i;
    assign inReady_o  = ready_q;
    assign outValid_o = (state_q != ST_EMPTY);
    assign outData_o  = mainData_q;

    // Occupancy FSM: route accepted beats into main or skid and drain in order.
    always_comb begin
        state_d    = state_q;
        mainData_d = mainData_q;
        skidData_d = skidData_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d    = ST_ONE;
                    mainData_d = inData_i;
                end
            end
            ST_ONE: begin
                if (accept && transfer) begin
                    mainData_d = inData_i;
                end else if (accept) begin
                    state_d    = ST_TWO;
                    skidData_d = inData_i;
                end else if (transfer) begin
                    state_d    = ST_EMPTY;
                    mainData_d = '0;
                end
            end
            ST_TWO: begin
                if (transfer) begin
                    state_d    = ST_ONE;
                    mainData_d = skidData_q;
                    skidData_d = '0;
                end
            end
            default: begin
                state_d    = ST_EMPTY;
                mainData_d = '0;
                skidData_d = '0;
            end
        endcase
        ready_d = (state_d != ST_TWO);
    end

    // State and storage registers; reset discards both entries.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_EMPTY;
            mainData_q <= '0;
            skidData_q <= '0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            mainData_q <= mainData_d;
            skidData_q <= skidData_d;
            ready_q    <= ready_d;
        end
    end

endmodule

// File: rtl/decoder4to10_seq.sv
// Registered 4-to-10 BCD decoder on a valid/ready stream. The code is decoded
// at accept and stored with its error flag in a two-entry skid buffer.
// Build option DEC_ERR_CNT_EN: when defined, a saturating counter of accepted
// invalid codes drives o_err_cnt; otherwise o_err_cnt is tied to zero.
module decoder4to10_seq
    import decoder4to10_seq_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input logic               i_clk,
    input logic               i_rst,
    decoder4to10_seq_if.slave bus
);

    beat_t decBeat;
    beat_t outBeat;
    logic  skidReady;

    assign decBeat = decodeBcd(bus.i_code);

    dec_skid_buf #(
        .WIDTH(DATA_W + 1)
    ) u_skid (
        .clk_i      (i_clk),
        .rst_i      (i_rst),
        .inValid_i  (bus.i_valid),
        .inReady_o  (skidReady),
        .inData_i   (decBeat),
        .outValid_o (bus.o_valid),
        .outReady_i (bus.i_ready),
        .outData_o  (outBeat)
    );

    assign bus.o_ready = skidReady;
    assign bus.o_data  = outBeat.data;
    assign bus.o_err   = outBeat.err;

`ifdef DEC_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] errCnt_q, errCnt_d;
    logic                 accept;

    assign accept = bus.i_valid & skidReady;

    // Count accepted invalid codes, holding at all-ones instead of wrapping.
    always_comb begin
        errCnt_d = errCnt_q;
        if (accept && decBeat.err && (errCnt_q != {ERR_CNT_W{1'b1}})) begin
            errCnt_d = errCnt_q + ERR_CNT_W'(1);
        end
    end

    // Counter register, cleared by reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            errCnt_q <= '0;
        end else begin
            errCnt_q <= errCnt_d;
        end
    end

    assign bus.o_err_cnt = errCnt_q;
`else
    assign bus.o_err_cnt = {ERR_CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_decoder4to10_seq.sv
// Bench for decoder4to10_seq: a scoreboard queue is filled on every accepted
// input beat and drained as output beats transfer. Inputs change and outputs
// are sampled on the falling edge.
module tb_decoder4to10_seq;

    localparam int CNT_W = 3;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   errCntExp;
    logic [10:0] expQ[$];

    decoder4to10_seq_if #(.ERR_CNT_W(CNT_W)) bus ();

    decoder4to10_seq #(
        .ERR_CNT_W(CNT_W)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // Free-running clock, 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference decode: {err, one-hot}.
    function automatic logic [10:0] modelDecode(input logic [3:0] c);
        logic [9:0] d;
        logic       e;
        d = '0;
        e = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (c == 4'(k)) begin
                d[k] = 1'b1;
                e    = 1'b0;
            end
        end
        return {e, d};
    endfunction

    // Reference 10-to-4 encoder.
    function automatic logic [3:0] modelEncode(input logic [9:0] d);
        logic [3:0] c;
        c = 4'hF;
        for (int k = 0; k < 10; k++) begin
            if (d[k]) c = 4'(k);
        end
        return c;
    endfunction

    // Scoreboard producer and counter model, updated at each rising edge.
    always @(posedge clk) begin
        if (rst) begin
            expQ.delete();
            errCntExp = 0;
        end else if (bus.i_valid === 1'b1 && bus.o_ready === 1'b1) begin
            expQ.push_back(modelDecode(bus.i_code));
`ifdef DEC_ERR_CNT_EN
            if (bus.i_code > 4'd9 && errCntExp < SAT) errCntExp = errCntExp + 1;
`endif
        end
    end

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.o_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.o_valid); end
        checks++;
        if (bus.o_data !== 10'h0) begin errors++; $display("[TB] FAIL reset_data: got %h expected 000", bus.o_data); end
        checks++;
        if (bus.o_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", bus.o_ready); end
        checks++;
        if (bus.o_err_cnt !== 3'd0) begin errors++; $display("[TB] FAIL reset_cnt: got %0d expected 0", bus.o_err_cnt); end
        rst         = 1'b0;
        bus.i_valid = 1'b0;
    endtask

    task automatic test_sweep();
        logic [10:0] exp;
        int beatIdx = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            bus.i_ready = 1'b1;
            bus.i_valid = (i < 10);
            bus.i_code  = 4'(i);
            if (i >= 1 && i <= 10) begin
                checks++;
                if (bus.o_valid !== 1'b1) begin errors++; $display("[TB] FAIL sweep_rate: cycle %0d o_valid %b expected 1", i, bus.o_valid); end
            end
            if (i == 11) begin
                checks++;
                if ({bus.o_valid, bus.o_err, bus.o_data} !== 12'h0) begin
                    errors++; $display("[TB] FAIL sweep_idle: got v=%b e=%b d=%h expected all 0", bus.o_valid, bus.o_err, bus.o_data);
                end
            end
            if (bus.o_valid === 1'b1 && bus.i_ready === 1'b1) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++; $display("[TB] FAIL sweep_extra: unexpected beat %h", bus.o_data);
                end else begin
                    exp = expQ.pop_front();
                    if ({bus.o_err, bus.o_data} !== exp) begin
                        errors++; $display("[TB] FAIL sweep_data: got %h expected %h", {bus.o_err, bus.o_data}, exp);
                    end
                end
                checks++;
                if (modelEncode(bus.o_data) !== 4'(beatIdx)) begin
                    errors++; $display("[TB] FAIL sweep_encode: got %0d expected %0d", modelEncode(bus.o_data), beatIdx);
                end
                beatIdx++;
            end
        end
    endtask

    task automatic test_invalid();
        logic [10:0] exp;
        int expCnt;
`ifdef DEC_ERR_CNT_EN
        expCnt = 6;
`else
        expCnt = 0;
`endif
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.i_ready = 1'b1;
            bus.i_valid = (i < 6);
            bus.i_code  = (i < 6) ? 4'(10 + i) : 4'd0;
            if (bus.o_valid === 1'b1 && bus.i_ready === 1'b1) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++; $display("[TB] FAIL invalid_extra: unexpected beat %h", bus.o_data);
                end else begin
                    exp = expQ.pop_front();
                    if ({bus.o_err, bus.o_data} !== exp) begin
                        errors++; $display("[TB] FAIL invalid_data: got %h expected %h", {bus.o_err, bus.o_data}, exp);
                    end
                end
            end
        end
        checks++;
        if (bus.o_err_cnt !== 3'(expCnt)) begin
            errors++; $display("[TB] FAIL invalid_cnt: got %0d expected %0d", bus.o_err_cnt, expCnt);
        end
    endtask

    task automatic test_backpressure();
        logic [10:0] exp;
        @(negedge clk);
        bus.i_ready = 1'b0; bus.i_valid = 1'b1; bus.i_code = 4'd3;
        @(negedge clk);
        bus.i_code = 4'd7;
        checks++;
        if ({bus.o_valid, bus.o_ready, bus.o_data} !== {2'b11, 10'h008}) begin
            errors++; $display("[TB] FAIL bp_first: got v=%b r=%b d=%h expected v=1 r=1 d=008", bus.o_valid, bus.o_ready, bus.o_data);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.i_valid = 1'b0;
            checks++;
            if ({bus.o_valid, bus.o_ready, bus.o_data} !== {2'b10, 10'h008}) begin
                errors++; $display("[TB] FAIL bp_hold: got v=%b r=%b d=%h expected v=1 r=0 d=008", bus.o_valid, bus.o_ready, bus.o_data);
            end
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.i_ready = 1'b1;
            checks++;
            if ({bus.o_valid, bus.o_data} !== {1'b1, (i == 0) ? 10'h008 : 10'h080}) begin
                errors++; $display("[TB] FAIL bp_drain: beat %0d got v=%b d=%h", i, bus.o_valid, bus.o_data);
            end
            checks++;
            if (expQ.size() == 0) begin
                errors++; $display("[TB] FAIL bp_queue: beat %0d missing from scoreboard", i);
            end else begin
                exp = expQ.pop_front();
                if ({bus.o_err, bus.o_data} !== exp) begin
                    errors++; $display("[TB] FAIL bp_order: got %h expected %h", {bus.o_err, bus.o_data}, exp);
                end
            end
        end
        @(negedge clk);
        checks++;
        if ({bus.o_valid, bus.o_ready, bus.o_data} !== {2'b01, 10'h000}) begin
            errors++; $display("[TB] FAIL bp_empty: got v=%b r=%b d=%h expected v=0 r=1 d=000", bus.o_valid, bus.o_ready, bus.o_data);
        end
    endtask

    task automatic test_saturation();
        logic [10:0] exp;
        int expCnt;
`ifdef DEC_ERR_CNT_EN
        expCnt = SAT;
`else
        expCnt = 0;
`endif
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            bus.i_ready = 1'b1;
            bus.i_valid = (i < 10);
            bus.i_code  = 4'(10 + (i % 6));
            checks++;
            if (bus.o_err_cnt !== 3'(errCntExp)) begin
                errors++; $display("[TB] FAIL sat_track: cycle %0d got %0d expected %0d", i, bus.o_err_cnt, errCntExp);
            end
            if (bus.o_valid === 1'b1 && bus.i_ready === 1'b1) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++; $display("[TB] FAIL sat_extra: unexpected beat %h", bus.o_data);
                end else begin
                    exp = expQ.pop_front();
                    if ({bus.o_err, bus.o_data} !== exp) begin
                        errors++; $display("[TB] FAIL sat_data: got %h expected %h", {bus.o_err, bus.o_data}, exp);
                    end
                end
            end
        end
        checks++;
        if (bus.o_err_cnt !== 3'(expCnt)) begin
            errors++; $display("[TB] FAIL sat_final: got %0d expected %0d", bus.o_err_cnt, expCnt);
        end
    endtask

    task automatic test_reset_midop();
        @(negedge clk);
        bus.i_ready = 1'b0; bus.i_valid = 1'b1; bus.i_code = 4'd1;
        @(negedge clk);
        bus.i_code = 4'd2;
        @(negedge clk);
        bus.i_valid = 1'b0;
        checks++;
        if (bus.o_ready !== 1'b0) begin errors++; $display("[TB] FAIL midop_full: o_ready %b expected 0", bus.o_ready); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.i_ready = 1'b1;
        checks++;
        if ({bus.o_valid, bus.o_ready, bus.o_data, bus.o_err_cnt} !== {2'b01, 10'h000, 3'd0}) begin
            errors++; $display("[TB] FAIL midop_reset: got v=%b r=%b d=%h cnt=%0d expected v=0 r=1 d=000 cnt=0",
                               bus.o_valid, bus.o_ready, bus.o_data, bus.o_err_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.o_valid !== 1'b0) begin errors++; $display("[TB] FAIL midop_ghost: stale beat %h appeared", bus.o_data); end
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] exp;
        for (int i = 0; i < 308; i++) begin
            @(negedge clk);
            bus.i_valid = (i < 300) && ($urandom_range(0, 3) != 0);
            bus.i_code  = 4'($urandom_range(0, 15));
            bus.i_ready = (i >= 300) || ($urandom_range(0, 2) != 0);
            checks++;
            if ({bus.o_valid, bus.o_ready} !== {expQ.size() != 0, expQ.size() < 2}) begin
                errors++; $display("[TB] FAIL b2b_occupancy: cycle %0d got v=%b r=%b for %0d stored", i, bus.o_valid, bus.o_ready, expQ.size());
            end
            checks++;
            if (bus.o_err_cnt !== 3'(errCntExp)) begin
                errors++; $display("[TB] FAIL b2b_cnt: cycle %0d got %0d expected %0d", i, bus.o_err_cnt, errCntExp);
            end
            if (bus.o_valid === 1'b1 && bus.i_ready === 1'b1) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++; $display("[TB] FAIL b2b_extra: unexpected beat %h", bus.o_data);
                end else begin
                    exp = expQ.pop_front();
                    if ({bus.o_err, bus.o_data} !== exp) begin
                        errors++; $display("[TB] FAIL b2b_data: cycle %0d got %h expected %h", i, {bus.o_err, bus.o_data}, exp);
                    end
                end
            end
        end
        checks++;
        if (expQ.size() != 0) begin errors++; $display("[TB] FAIL b2b_drain: %0d beats never delivered, expected 0", expQ.size()); end
    endtask

    // Test sequence.
    initial begin
        checks      = 0;
        errors      = 0;
        errCntExp   = 0;
        rst         = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_code  = 4'd5;
        bus.i_ready = 1'b1;
        test_reset();
        test_sweep();
        test_invalid();
        test_backpressure();
        test_saturation();
        test_reset_midop();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
